// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell (two half adders + OR) reused over
// WIDTH clocks, LSB first, with a start/busy/done handshake.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             s0, c0, s_bit, c1, c_bit;

    half_adder u_ha0 (.x(a_sr[0]), .y(b_sr[0]), .s(s0),    .c(c0));
    half_adder u_ha1 (.x(s0),      .y(carry),   .s(s_bit), .c(c1));
    assign c_bit = c0 | c1;

    // New bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_one
            assign res_next = s_bit;
        end else begin : g_multi
            assign res_next = {s_bit, res_sr[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        carry  <= cin;
                        res_sr <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= c_bit;
                    res_sr <= res_next;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum   <= res_next;
                        cout  <= c_bit;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Multi-bit adder that reuses a single 1-bit adder cell over WIDTH clock cycles, one bit per cycle, LSB first.
- The cell is two half-adder instances plus an OR for carry-out.
- Contains the sequencer: operand/result shift registers, bit counter, carry flop and a start/busy/done handshake.
- Serves as the area-minimal adder for serial datapaths; a parallel adder is the alternative where area is not the constraint.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request an add; sampled only in IDLE or DONE.
a  input  WIDTH  operand A; sampled on the accepting edge only.
b  input  WIDTH  operand B; sampled on the accepting edge only.
cin  input  1  carry-in; sampled on the accepting edge only.
busy  output  1  high while the add is in progress (RUN state).
done  output  1  one-cycle pulse: sum and cout are valid.
sum  output  WIDTH  result; held stable from done until the next accepted start completes.
cout  output  1  final carry-out; held with sum.

Behaviour:
- Reset (rst_n=0, async, any time including mid-operation):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry flop and bit counter are cleared.
  - No partial result survives reset.
- FSM states: IDLE, RUN, DONE. All outputs are registered, with no combinational path from inputs.
- IDLE:
  - start=1 at edge k accepts the add: latch a, b into shift registers, load carry flop with cin, clear counter, go to RUN.
  - start=0: stay in IDLE; sum and cout hold.
- RUN:
  - busy=1 for exactly WIDTH cycles, from edge k to edge k+WIDTH.
  - Each edge: the cell computes s = a_sr[0]^b_sr[0]^carry and c = majority(a_sr[0], b_sr[0], carry).
  - s shifts into the MSB of the result shift register; a_sr and b_sr shift right; carry is updated with c; the counter increments.
  - At the edge where the counter reaches WIDTH-1 (edge k+WIDTH): go to DONE, load sum from the result register, load cout from c.
  - start during RUN is ignored and has no side effect; a, b and cin changes during RUN are ignored.
- DONE:
  - done=1 and busy=0 for exactly one cycle, the cycle after edge k+WIDTH. Latency from the accepting edge to done is WIDTH clocks.
  - Next edge: with start=1, accept a new add exactly as from IDLE (back-to-back, no idle bubble) and clear done. With start=0, go to IDLE and clear done.
- Arithmetic: {cout, sum} = a + b + cin, unsigned, modulo 2^(WIDTH+1). No overflow flag; wrap-around appears only as cout=1.
- Counter width is clog2(WIDTH) bits, minimum 1. WIDTH=1 gives a single RUN cycle.
- sum and cout change only on the DONE-entry edge or on reset.

Test Plan:
1. WIDTH=8, reset then start pulse with a=0x5A, b=0x3C, cin=0 -> busy high 8 cycles; done pulses once, 8 clocks after the accept edge; sum=0x96, cout=0.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Then a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0, done still pulses.
3. Start a=0x10, b=0x20. At RUN cycle 3, assert start with a=0xAA, b=0x55 and change the a/b pins -> result is 0x30, cout=0, single done; the second start is dropped and busy stays continuous.
4. Back-to-back: start held high through the DONE cycle with a=0x01, b=0x02, then a=0x7F, b=0x01 -> first done gives sum=0x03; busy re-asserts on the next edge; second done follows 8 clocks later with sum=0x80, cout=0.
5. Reset mid-op: start a=0xF0, b=0x0F; drop rst_n asynchronously (between edges) at RUN cycle 5 -> busy, done, sum and cout go to 0 immediately. After release, no done pulse occurs without a new start, and a fresh add of 0x22+0x11 returns 0x33.
6. WIDTH=1 instance, all 8 combinations of a, b, cin -> done 1 clock after the accept edge, {cout, sum} equals the 2-bit sum; a=1, b=1, cin=0 gives sum=0, cout=1.
